// File: rtl/multdiv_ctrl_pkg.sv
// rtl/multdiv_ctrl_pkg.sv - shared constants, state encoding and decode helper for multdiv_ctrl
package multdiv_ctrl_pkg;

    localparam logic [4:0]  OP_ALU     = 5'b00000;
    localparam logic [4:0]  ALU_MUL    = 5'b00110;
    localparam logic [4:0]  ALU_DIV    = 5'b00111;

    localparam logic [31:0] ST_MUL_EXC = 32'd4;
    localparam logic [31:0] ST_DIV_EXC = 32'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // True when instr is an R-type ALU instruction with the given ALU op.
    function automatic logic is_md_op(input logic [31:0] instr, input logic [4:0] alu_op);
        return (instr[31:27] == OP_ALU) && (instr[6:2] == alu_op);
    endfunction

endpackage

// File: rtl/multdiv_ctrl_timeout_counter.sv
// rtl/multdiv_ctrl_timeout_counter.sv - saturating BUSY-cycle counter with terminal-count flag
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-low reset
//   clr    restart the count at 0 (takes priority over en)
//   en     count this cycle
//   tc     count equals TIMEOUT_CYCLES-1
module md_timeout_counter #(
    parameter int CNT_W          = 6,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Holds at all-ones rather than wrapping, so tc can never re-fire.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - X-stage sequencing controller for the multi-cycle multiply/divide unit
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-low reset
//   instr_x, valid_x     instruction in X and its valid flag
//   flush_x              X is squashed this cycle
//   md_ready, md_exc     unit result valid / exception (exc meaningful only with ready)
//   ctrl_mult, ctrl_div  one-cycle start pulses to the unit
//   stall                freeze PC, F/D, D/X; bubble into X/M
//   md_done, md_rd       writeback strobe and destination register
//   status_we/val        rstatus write on exception or timeout
//   busy                 controller not idle
import multdiv_ctrl_pkg::*;

module multdiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_x,
    input  logic        valid_x,
    input  logic        flush_x,
    input  logic        md_ready,
    input  logic        md_exc,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        md_done,
    output logic [4:0]  md_rd,
    output logic        status_we,
    output logic [31:0] status_val,
    output logic        busy
);

    md_state_t state, state_nx;

    logic is_mul, is_div, start_cond, tc;
    logic op_is_div, exc_q;

    assign is_mul     = is_md_op(instr_x, ALU_MUL);
    assign is_div     = is_md_op(instr_x, ALU_DIV);
    assign start_cond = valid_x & ~flush_x & (is_mul | is_div) & (state == IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Flush outranks a same-cycle result; a result outranks timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_cond) state_nx = BUSY;
            BUSY: begin
                if (flush_x) begin
                    state_nx = IDLE;
                end else if (md_ready || tc) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            op_is_div <= 1'b0;
            md_rd     <= 5'd0;
            exc_q     <= 1'b0;
        end else begin
            ctrl_mult <= start_cond & is_mul;
            ctrl_div  <= start_cond & is_div;
            if (start_cond) begin
                op_is_div <= is_div;
                md_rd     <= instr_x[26:22];
                exc_q     <= 1'b0;
            end else if ((state == BUSY) && !flush_x) begin
                // Exception flag for the DONE cycle: unit-reported or forced by timeout.
                if (md_ready) begin
                    exc_q <= md_exc;
                end else if (tc) begin
                    exc_q <= 1'b1;
                end
            end
        end
    end

    md_timeout_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (start_cond),
        .en    (state == BUSY),
        .tc    (tc)
    );

    // Gated by reset so the pipeline is never frozen while reset is held.
    assign stall      = reset & (start_cond | (state == BUSY));
    assign md_done    = (state == DONE);
    assign status_we  = md_done & exc_q;
    assign status_val = status_we ? (op_is_div ? ST_DIV_EXC : ST_MUL_EXC) : 32'd0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - scoreboard testbench for multdiv_ctrl
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_x = 32'd0;
    logic        valid_x = 1'b0;
    logic        flush_x = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_exc = 1'b0;
    logic        ctrl_mult, ctrl_div, stall, md_done, status_we, busy;
    logic [4:0]  md_rd;
    logic [31:0] status_val;

    multdiv_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_x    (instr_x),
        .valid_x    (valid_x),
        .flush_x    (flush_x),
        .md_ready   (md_ready),
        .md_exc     (md_exc),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .stall      (stall),
        .md_done    (md_done),
        .md_rd      (md_rd),
        .status_we  (status_we),
        .status_val (status_val),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic is_div;
        int   gap;
    } pulse_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] val;
    } done_t;

    pulse_t pq[$];
    done_t  dq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor: pops expectations whenever the DUT presents a pulse or writeback.
    always @(negedge clock) begin
        if (ctrl_mult || ctrl_div) begin
            check("pulse_expected", 32'(pq.size() > 0), 32'd1);
            if (pq.size() > 0) begin
                pulse_t p;
                p = pq.pop_front();
                check("pulse_mult", 32'(ctrl_mult), 32'(!p.is_div));
                check("pulse_div", 32'(ctrl_div), 32'(p.is_div));
                if (p.gap >= 0) check("pulse_gap", 32'(cyc - last_done_cyc), 32'(p.gap));
            end
        end
        if (md_done) begin
            last_done_cyc = cyc;
            check("done_expected", 32'(dq.size() > 0), 32'd1);
            if (dq.size() > 0) begin
                done_t d;
                d = dq.pop_front();
                check("done_rd", 32'(md_rd), 32'(d.rd));
                check("done_status_we", 32'(status_we), 32'(d.we));
                check("done_status_val", status_val, d.val);
            end
        end
    end

    task automatic run_op(input logic [31:0] instr, input int ready_at, input logic exc,
                          input int flush_at, output int stall_cnt, output logic got_done);
        logic fin;
        stall_cnt = 0;
        got_done  = 1'b0;
        fin       = 1'b0;
        @(negedge clock);
        instr_x = instr; valid_x = 1'b1; md_ready = 1'b0; md_exc = 1'b0; flush_x = 1'b0;
        #1 stall_cnt += int'(stall);
        for (int b = 1; b <= 60 && !fin; b++) begin
            @(negedge clock);
            if (md_done) begin
                got_done = 1'b1;
                fin = 1'b1;
                valid_x = 1'b0; md_ready = 1'b0; md_exc = 1'b0; flush_x = 1'b0;
                #1 check("stall_low_in_done", 32'(stall), 32'd0);
            end else if (!busy) begin
                fin = 1'b1;
                valid_x = 1'b0; md_ready = 1'b0; md_exc = 1'b0; flush_x = 1'b0;
                #1 check("stall_low_after_abort", 32'(stall), 32'd0);
            end else begin
                md_ready = (b == ready_at);
                md_exc   = exc && (b == ready_at);
                flush_x  = (b == flush_at);
                #1 stall_cnt += int'(stall);
            end
        end
        check("op_finished_in_bound", 32'(fin), 32'd1);
        valid_x = 1'b0; md_ready = 1'b0; md_exc = 1'b0; flush_x = 1'b0;
    endtask

    int   sc;
    logic gd;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_md_done", 32'(md_done), 32'd0);
        check("rst_ctrl", 32'(ctrl_mult | ctrl_div), 32'd0);
        check("rst_status_we", 32'(status_we), 32'd0);
        check("rst_md_rd", 32'(md_rd), 32'd0);
        reset = 1'b1;

        // Non-md ALU op and a flushed md op must not start anything
        @(negedge clock);
        instr_x = 32'h00C00014; valid_x = 1'b1;
        #1 check("nonmd_stall", 32'(stall), 32'd0);
        @(negedge clock);
        check("nonmd_busy", 32'(busy), 32'd0);
        instr_x = 32'h00C00018; flush_x = 1'b1;
        #1 check("flushed_start_stall", 32'(stall), 32'd0);
        @(negedge clock);
        check("flushed_start_busy", 32'(busy), 32'd0);
        valid_x = 1'b0; flush_x = 1'b0;

        // 1: mul rd=3, result on 4th BUSY cycle
        pq.push_back('{1'b0, -1});
        dq.push_back('{5'd3, 1'b0, 32'd0});
        run_op(32'h00C00018, 4, 1'b0, 0, sc, gd);
        check("t1_stall_cycles", 32'(sc), 32'd5);
        check("t1_done", 32'(gd), 32'd1);

        // 2: div rd=5 with unit exception
        pq.push_back('{1'b1, -1});
        dq.push_back('{5'd5, 1'b1, 32'd5});
        run_op(32'h0140001C, 2, 1'b1, 0, sc, gd);
        check("t2_stall_cycles", 32'(sc), 32'd3);

        // 3: mul rd=9, no result -> timeout after 40 BUSY cycles
        pq.push_back('{1'b0, -1});
        dq.push_back('{5'd9, 1'b1, 32'd4});
        run_op(32'h02400018, 0, 1'b0, 0, sc, gd);
        check("t3_stall_cycles", 32'(sc), 32'd41);
        check("t3_done", 32'(gd), 32'd1);

        // 3b: result arrives on the timeout cycle itself -> normal completion wins
        pq.push_back('{1'b0, -1});
        dq.push_back('{5'd9, 1'b0, 32'd0});
        run_op(32'h02400018, 40, 1'b0, 0, sc, gd);
        check("t3b_stall_cycles", 32'(sc), 32'd41);

        // 4: div aborted by flush on 3rd BUSY cycle with simultaneous md_ready
        pq.push_back('{1'b1, -1});
        run_op(32'h0140001C, 3, 1'b1, 3, sc, gd);
        check("t4_stall_cycles", 32'(sc), 32'd4);
        check("t4_no_done", 32'(gd), 32'd0);
        check("t4_status_we", 32'(status_we), 32'd0);

        // 5: back-to-back mul then div at minimum latency
        pq.push_back('{1'b0, -1});
        dq.push_back('{5'd3, 1'b0, 32'd0});
        run_op(32'h00C00018, 1, 1'b0, 0, sc, gd);
        check("t5a_stall_cycles", 32'(sc), 32'd2);
        check("t5a_md_rd", 32'(md_rd), 32'd3);
        pq.push_back('{1'b1, 2});
        dq.push_back('{5'd5, 1'b0, 32'd0});
        run_op(32'h0140001C, 1, 1'b0, 0, sc, gd);
        check("t5b_stall_cycles", 32'(sc), 32'd2);
        check("t5b_md_rd", 32'(md_rd), 32'd5);

        // 6: reset mid-BUSY, later md_ready ignored
        pq.push_back('{1'b0, -1});
        @(negedge clock);
        instr_x = 32'h01C00018; valid_x = 1'b1;
        repeat (3) @(negedge clock);
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_stall", 32'(stall), 32'd0);
        check("t6_rst_md_done", 32'(md_done), 32'd0);
        check("t6_rst_ctrl", 32'(ctrl_mult | ctrl_div), 32'd0);
        check("t6_rst_status_we", 32'(status_we), 32'd0);
        check("t6_rst_status_val", status_val, 32'd0);
        check("t6_rst_md_rd", 32'(md_rd), 32'd0);
        reset = 1'b1; valid_x = 1'b0;
        @(negedge clock);
        md_ready = 1'b1;
        @(negedge clock);
        md_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_late_ready_no_done", 32'(md_done), 32'd0);
            check("t6_late_ready_idle", 32'(busy), 32'd0);
        end

        check("pulse_queue_empty", 32'(pq.size()), 32'd0);
        check("done_queue_empty", 32'(dq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
